set_assoc_cache_controller: RTL and testbench
=============================================

Name: set_assoc_cache_controller

Overview:
- Parametrised 2-way set-associative, write-through, read-allocate cache controller for the memory stage.
- Sits between the pipeline's memory-stage request (rdEn/wrEn/address/writeData) and the SRAM controller's line-wide handshake.
- Generalises the fixed-geometry cache: configurable set count, words per line, address base and width. Adds an explicit flush and saturating hit/miss counters.
- Drives `ready`. The memory stage derives `freeze = ~ready`.

Parameters:
- ADDR_W, 32, request address width (byte address).
- SETS, 64, sets per way; power of two, 2 to 1024.
- WORDS_PER_LINE, 2, 32-bit words per line; power of two, 1 to 8.
- BASE_ADDR, 1024, subtracted from `address` before decoding.
- CNT_W, 16, width of the hit and miss counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- rdEn  in  1  load request; held by the pipeline until `ready`.
- wrEn  in  1  store request; held until `ready`.
- address  in  ADDR_W  byte address.
- writeData  in  32  store data.
- flush  in  1  invalidate all lines.
- readData  out  32  load result; valid when `rdEn & ready`.
- ready  out  1  request complete / no request pending.
- sramReady  in  1  one-cycle completion pulse from the SRAM controller.
- sramReadData  in  32*WORDS_PER_LINE  fetched line; word 0 in the LSBs.
- sramWrEn  out  1  SRAM word-write request.
- sramRdEn  out  1  SRAM line-read request.
- sramAddress  out  ADDR_W  word address to SRAM: `address` for writes, line-aligned `address` for reads.
- hitCount  out  CNT_W  saturating load-hit counter.
- missCount  out  CNT_W  saturating load-miss counter.

Behaviour:
- Decode of `off = address - BASE_ADDR`:
  - bits [1:0] ignored;
  - next log2(WORDS_PER_LINE) bits select the word;
  - next log2(SETS) bits select the set;
  - the remaining bits are the tag.
- Storage per set: two ways, each holding valid, tag and line data; one LRU bit per set (0 means way 0 is the victim).
- States: IDLE, RD_MISS, WR_THRU.
- IDLE:
  - `wrEn=1`: go to WR_THRU. `wrEn` has priority when `rdEn` and `wrEn` are both 1.
  - `rdEn=1` and hit: `readData` is combinational from the hit way and `ready=1` in the same cycle (0-cycle latency). The LRU bit points at the other way; `hitCount` increments.
  - `rdEn=1` and miss: go to RD_MISS; `missCount` increments once on entry.
  - No request: `ready=1`.
- RD_MISS:
  - `sramRdEn=1` and `ready=0` until `sramReady`.
  - On the `sramReady` cycle:
    - write the line into the victim way: the invalid way first, else way 0 if both are invalid, else the LRU way;
    - set valid and tag; the LRU bit points at the other way;
    - drive `readData` from the selected word of `sramReadData`;
    - `ready=1`; return to IDLE.
- WR_THRU:
  - `sramWrEn=1` and `ready=0` until `sramReady`.
  - On a hit, update the cached word on the entry cycle. A write miss does not allocate.
  - Write does not update LRU or the counters.
  - `ready=1` on the `sramReady` cycle; return to IDLE.
- `sramRdEn` and `sramWrEn` are never 1 together. Each drops the cycle after `sramReady`.
- flush:
  - honoured only in IDLE with no request: clears every valid bit and LRU bit in one cycle;
  - in RD_MISS or WR_THRU it is ignored; the requester re-asserts it;
  - flush plus a request in IDLE: the request is served and flush is ignored.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Reset:
  - state=IDLE, all valid and LRU bits cleared, counters=0;
  - `sramRdEn=0`, `sramWrEn=0`, `readData=0` when not hitting, `ready=1` when idle;
  - reset mid-miss abandons the transfer; a `sramReady` arriving after reset is ignored.
- `sramReady` while in IDLE is ignored.
- The line data array may be flops or an inferred RAM with asynchronous read; a hit must remain 0-cycle.

Test Plan:
- Reset, then load 1024: miss; `sramRdEn` held until `sramReady`; line {0xBBBB0002,0xAAAA0001} returned → `readData=0xAAAA0001`; load 1028 → same-cycle hit, `readData=0xBBBB0002`; hitCount=1, missCount=1.
- Loads to 1024, 1536 and 2048 (all set 0; defaults): 2048 evicts the 1024 line (LRU). A following load of 1536 hits; a load of 1024 misses.
- Store 0x12345678 to 1024 after it is cached → `sramWrEn` asserted with sramAddress=1024; `ready` only on `sramReady`. A later load of 1024 hits, `readData=0x12345678`. Store to uncached 4000, then load 4000 → miss.
- `rdEn=wrEn=1` in IDLE → WR_THRU taken; `sramRdEn` stays 0.
- Flush in IDLE after three cached lines → next load of each misses. Flush pulsed during RD_MISS → ignored; the fill completes and the line stays valid.
- CNT_W=4: 20 hits → hitCount=15. rst asserted mid-RD_MISS, then a late `sramReady` → state IDLE, no line filled, counters 0.

Source files
------------

// File: rtl/set_assoc_cache_controller.sv
// 2-way set-associative, write-through, read-allocate cache controller for the memory stage.
// Loads hit in zero cycles; misses fetch a whole line from the SRAM controller.
module set_assoc_cache_controller #(
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned SETS           = 64,
    parameter int unsigned WORDS_PER_LINE = 2,
    parameter int unsigned BASE_ADDR      = 1024,
    parameter int unsigned CNT_W          = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rdEn,
    input  logic                         wrEn,
    input  logic [ADDR_W-1:0]            address,
    input  logic [31:0]                  writeData,
    input  logic                         flush,
    output logic [31:0]                  readData,
    output logic                         ready,
    input  logic                         sramReady,
    input  logic [32*WORDS_PER_LINE-1:0] sramReadData,
    output logic                         sramWrEn,
    output logic                         sramRdEn,
    output logic [ADDR_W-1:0]            sramAddress,
    output logic [CNT_W-1:0]             hitCount,
    output logic [CNT_W-1:0]             missCount
);

    localparam int unsigned WO_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned WI_W   = (WO_W > 0) ? WO_W : 1;
    localparam int unsigned SET_W  = $clog2(SETS);
    localparam int unsigned TAG_W  = ADDR_W - 2 - WO_W - SET_W;
    localparam int unsigned LINE_W = 32 * WORDS_PER_LINE;

    localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'((64'd1 << (2 + WO_W)) - 64'd1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StRdMiss = 2'd1;
    localparam logic [1:0] StWrThru = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [SETS-1:0]   valid_q [2];
    logic [SETS-1:0]   valid_d [2];
    logic [SETS-1:0]   lru_q, lru_d;
    logic [TAG_W-1:0]  tag_q [2][SETS];
    logic [LINE_W-1:0] data_q [2][SETS];
    logic [CNT_W-1:0]  hit_cnt_q, hit_cnt_d;
    logic [CNT_W-1:0]  miss_cnt_q, miss_cnt_d;

    logic [ADDR_W-1:0] off;
    logic [WI_W-1:0]   word_idx;
    logic [SET_W-1:0]  set_idx;
    logic [TAG_W-1:0]  req_tag;
    logic              hit0, hit1, hit, hit_way, victim;
    logic [LINE_W-1:0] hit_line;
    logic              line_we, tag_we, line_way;
    logic [LINE_W-1:0] line_wdata;

    assign off      = address - ADDR_W'(BASE_ADDR);
    assign word_idx = (WO_W > 0) ? WI_W'(off >> 2) : '0;
    assign set_idx  = SET_W'(off >> (2 + WO_W));
    assign req_tag  = TAG_W'(off >> (2 + WO_W + SET_W));

    assign hit0     = valid_q[0][set_idx] && (tag_q[0][set_idx] == req_tag);
    assign hit1     = valid_q[1][set_idx] && (tag_q[1][set_idx] == req_tag);
    assign hit      = hit0 | hit1;
    assign hit_way  = hit1;
    assign hit_line = data_q[hit_way][set_idx];

    // Fill target: an invalid way if any (way 0 preferred), otherwise the LRU way.
    assign victim = !valid_q[0][set_idx] ? 1'b0 :
                    !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];

    assign sramAddress = (state_q == StRdMiss) ? (address & ~LINE_MASK) : address;
    assign hitCount    = hit_cnt_q;
    assign missCount   = miss_cnt_q;

    always_comb begin
        state_d    = state_q;
        valid_d    = valid_q;
        lru_d      = lru_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        ready      = 1'b0;
        readData   = '0;
        sramRdEn   = 1'b0;
        sramWrEn   = 1'b0;
        line_we    = 1'b0;
        tag_we     = 1'b0;
        line_way   = hit_way;
        line_wdata = sramReadData;

        case (state_q)
            StIdle: begin
                if (wrEn) begin
                    state_d = StWrThru;
                    if (hit) begin
                        line_we                         = 1'b1;
                        line_wdata                      = hit_line;
                        line_wdata[32*word_idx +: 32]   = writeData;
                    end
                end else if (rdEn) begin
                    if (hit) begin
                        ready            = 1'b1;
                        readData         = hit_line[32*word_idx +: 32];
                        lru_d[set_idx]   = ~hit_way;
                        if (hit_cnt_q != '1) hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end else begin
                        state_d = StRdMiss;
                        if (miss_cnt_q != '1) miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end else begin
                    ready = 1'b1;
                    if (flush) begin
                        valid_d[0] = '0;
                        valid_d[1] = '0;
                        lru_d      = '0;
                    end
                end
            end
            StRdMiss: begin
                sramRdEn = 1'b1;
                if (sramReady) begin
                    line_we                  = 1'b1;
                    tag_we                   = 1'b1;
                    line_way                 = victim;
                    valid_d[victim][set_idx] = 1'b1;
                    lru_d[set_idx]           = ~victim;
                    readData                 = sramReadData[32*word_idx +: 32];
                    ready                    = 1'b1;
                    state_d                  = StIdle;
                end
            end
            StWrThru: begin
                sramWrEn = 1'b1;
                if (sramReady) begin
                    ready   = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            valid_q[0] <= '0;
            valid_q[1] <= '0;
            lru_q      <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            valid_q    <= valid_d;
            lru_q      <= lru_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

    // Tag and line storage need no reset; validity alone qualifies them.
    always_ff @(posedge clk) begin
        if (!rst && line_we) data_q[line_way][set_idx] <= line_wdata;
        if (!rst && tag_we)  tag_q[line_way][set_idx]  <= req_tag;
    end

endmodule

// File: tb/tb_set_assoc_cache_controller.sv
// Self-checking bench: drives the memory-stage side, models the SRAM controller and memory,
// and compares load results through an expected-data scoreboard queue.
module tb_set_assoc_cache_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdEn, wrEn, flush, sramReady;
    logic [31:0] address, writeData;
    logic [63:0] sramReadData;
    logic [31:0] readData, sramAddress, rd4, sa4;
    logic        ready, sramWrEn, sramRdEn, rdy4, swe4, sre4;
    logic [15:0] hitCount, missCount;
    logic [3:0]  hit4, miss4;

    int          n_tests = 0;
    int          n_fail  = 0;
    int          exp_hits = 0;
    int          exp_misses = 0;
    logic [31:0] exp_q[$];
    logic [31:0] mem [logic [31:0]];

    always #5 clk = ~clk;

    set_assoc_cache_controller dut (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
        .writeData(writeData), .flush(flush), .readData(readData), .ready(ready),
        .sramReady(sramReady), .sramReadData(sramReadData), .sramWrEn(sramWrEn),
        .sramRdEn(sramRdEn), .sramAddress(sramAddress), .hitCount(hitCount),
        .missCount(missCount)
    );

    set_assoc_cache_controller #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .rdEn(rdEn), .wrEn(wrEn), .address(address),
        .writeData(writeData), .flush(flush), .readData(rd4), .ready(rdy4),
        .sramReady(sramReady), .sramReadData(sramReadData), .sramWrEn(swe4),
        .sramRdEn(sre4), .sramAddress(sa4), .hitCount(hit4), .missCount(miss4)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return 32'h5A00_0000 ^ a;
    endfunction

    function automatic logic [63:0] line_rd(input logic [31:0] a);
        logic [31:0] b;
        b = a & ~32'h7;
        return {mem_rd(b + 32'd4), mem_rd(b)};
    endfunction

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_hit"}, hitCount, exp_hits);
        check({tag, "_miss"}, missCount, exp_misses);
        check({tag, "_hit4"}, hit4, sat15(exp_hits));
        check({tag, "_miss4"}, miss4, sat15(exp_misses));
    endtask

    // Load with an expected hit/miss outcome; a miss is served after two wait cycles.
    task automatic load(input logic [31:0] a, input bit exp_hit, input bit flush_mid);
        logic [31:0] exp;
        @(posedge clk); #1;
        rdEn = 1'b1; wrEn = 1'b0; address = a;
        exp_q.push_back(mem_rd(a));
        @(negedge clk);
        check("load_ready_first", ready, exp_hit);
        if (ready) begin
            exp = exp_q.pop_front();
            check("hit_data", readData, exp);
            check("hit_no_sram_rd", sramRdEn, 1'b0);
        end else begin
            for (int i = 0; i < 2; i++) begin
                @(posedge clk); #1;
                flush = flush_mid && (i == 0);
                @(negedge clk);
                check("miss_sram_rd", sramRdEn, 1'b1);
                check("miss_no_sram_wr", sramWrEn, 1'b0);
                check("miss_wait_ready", ready, 1'b0);
                check("miss_line_addr", sramAddress, a & ~32'h7);
            end
            @(posedge clk); #1;
            flush = 1'b0; sramReady = 1'b1; sramReadData = line_rd(a);
            @(negedge clk);
            check("fill_ready", ready, 1'b1);
            exp = exp_q.pop_front();
            check("fill_data", readData, exp);
        end
        @(posedge clk); #1;
        rdEn = 1'b0; sramReady = 1'b0;
        @(negedge clk);
        check("rd_drop", sramRdEn, 1'b0);
        if (exp_hit) exp_hits++;
        else exp_misses++;
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d, input bit also_rd);
        @(posedge clk); #1;
        wrEn = 1'b1; rdEn = also_rd; address = a; writeData = d;
        @(negedge clk);
        check("st_ready_first", ready, 1'b0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            @(negedge clk);
            check("st_sram_wr", sramWrEn, 1'b1);
            check("st_no_sram_rd", sramRdEn, 1'b0);
            check("st_wait_ready", ready, 1'b0);
            check("st_addr", sramAddress, a);
        end
        @(posedge clk); #1;
        sramReady = 1'b1;
        @(negedge clk);
        check("st_done_ready", ready, 1'b1);
        @(posedge clk); #1;
        sramReady = 1'b0; wrEn = 1'b0; rdEn = 1'b0;
        mem[a] = d;
        @(negedge clk);
        check("st_wr_drop", sramWrEn, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdEn = 1'b0; wrEn = 1'b0; flush = 1'b0; sramReady = 1'b0;
        address = '0; writeData = '0; sramReadData = '0;
        mem[32'd1024] = 32'hAAAA_0001;
        mem[32'd1028] = 32'hBBBB_0002;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ready", ready, 1'b1);
        check("rst_sram_rd", sramRdEn, 1'b0);
        check("rst_sram_wr", sramWrEn, 1'b0);
        check("rst_read_data", readData, 32'h0);
        check_counts("rst");

        // Fill then same-line hit.
        load(32'd1024, 1'b0, 1'b0);
        load(32'd1028, 1'b1, 1'b0);
        check_counts("first");

        // Set 0 conflict: LRU replacement.
        load(32'd1536, 1'b0, 1'b0);
        load(32'd2048, 1'b0, 1'b0);
        load(32'd1536, 1'b1, 1'b0);
        load(32'd1024, 1'b0, 1'b0);

        // Write-through hit updates the cached word; write miss does not allocate.
        store(32'd1024, 32'h1234_5678, 1'b0);
        load(32'd1024, 1'b1, 1'b0);
        store(32'd4000, 32'hCAFE_F00D, 1'b0);
        load(32'd4000, 1'b0, 1'b0);

        // Simultaneous read and write: the write wins.
        store(32'd1536, 32'h0BAD_BEEF, 1'b1);
        check_counts("rdwr");

        // Flush in idle invalidates every line.
        @(posedge clk); #1 flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        load(32'd1024, 1'b0, 1'b0);
        load(32'd1536, 1'b0, 1'b0);
        load(32'd4000, 1'b0, 1'b0);

        // Flush during a miss is ignored; the fill survives.
        load(32'd2048, 1'b0, 1'b1);
        load(32'd2048, 1'b1, 1'b0);

        for (int i = 0; i < 20; i++) load(32'd2052, 1'b1, 1'b0);
        check_counts("saturate");

        // Reset mid-miss, then a late sramReady must be ignored.
        @(posedge clk); #1;
        rdEn = 1'b1; address = 32'd1024;
        @(posedge clk); #1;
        @(negedge clk);
        check("pre_rst_sram_rd", sramRdEn, 1'b1);
        @(posedge clk); #1 rst = 1'b1; rdEn = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        exp_hits = 0; exp_misses = 0;
        sramReady = 1'b1; sramReadData = line_rd(32'd1024);
        @(negedge clk);
        check("late_ready_idle", ready, 1'b1);
        check("late_no_sram_rd", sramRdEn, 1'b0);
        @(posedge clk); #1 sramReady = 1'b0;
        @(negedge clk);
        check_counts("post_rst");
        load(32'd1024, 1'b0, 1'b0);
        check_counts("post_rst_load");

        check("scoreboard_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
